comb_sweep_gen: RTL and testbench



---
 rtl/comb_sweep_pkg.sv | 26 ++
 rtl/comb_sweep_gen_if.sv | 40 ++++
 rtl/sweep_bin2gray.sv | 17 +
 rtl/comb_sweep_gen.sv | 129 ++++++++++++
 tb/tb_comb_sweep_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/comb_sweep_pkg.sv
// comb_sweep_pkg
// Shared types and width helpers for the exhaustive combinational sweep
// engine (comb_sweep_gen) and its bus interface (comb_sweep_gen_if).
//   state_t     : sweep controller states
//   hold_cnt_w  : width of the per-vector hold counter for a given HOLD
//   ones_cnt_w  : width of the y[0]=1 vector counter for a given N_IN
package comb_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Hold counter only has to reach HOLD-1, so $clog2(HOLD) bits suffice.
    function automatic int hold_cnt_w(input int hold);
        return $clog2(hold);
    endfunction

    // The count can reach 2^N_IN, one more than an N_IN-bit value holds.
    function automatic int ones_cnt_w(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/comb_sweep_gen_if.sv
// comb_sweep_gen_if
// Bus between the sweep engine, the combinational circuit under test and
// the event consumer.
//   start    : begin a sweep (consumer -> engine)
//   busy     : sweep in progress
//   done     : one-cycle end-of-sweep pulse
//   vec      : vector applied to the circuit under test
//   dut_y    : circuit response
//   ev_valid/ev_ready/ev_vec/ev_y : output-change event handshake
//   ones_cnt : number of vectors whose sampled y[0] was 1
// Modports: master = sweep engine, slave = circuit/consumer side.
interface comb_sweep_gen_if
    import comb_sweep_pkg::*;
#(
    parameter int N_IN  = 5,
    parameter int N_OUT = 1
) ();

    logic                        start;
    logic                        busy;
    logic                        done;
    logic [N_IN-1:0]             vec;
    logic [N_OUT-1:0]            dut_y;
    logic                        ev_valid;
    logic                        ev_ready;
    logic [N_IN-1:0]             ev_vec;
    logic [N_OUT-1:0]            ev_y;
    logic [ones_cnt_w(N_IN)-1:0] ones_cnt;

    modport master (
        input  start, dut_y, ev_ready,
        output busy, done, vec, ev_valid, ev_vec, ev_y, ones_cnt
    );

    modport slave (
        output start, dut_y, ev_ready,
        input  busy, done, vec, ev_valid, ev_vec, ev_y, ones_cnt
    );

endinterface

// File: rtl/sweep_bin2gray.sv
// sweep_bin2gray
// Binary to reflected Gray code conversion used for the Gray-order sweep.
// Only compiled when SWEEP_GRAY_EN is defined.
//   bin  : binary index (W bits)
//   gray : Gray-coded vector (W bits)
`ifdef SWEEP_GRAY_EN
module sweep_bin2gray #(
    parameter int W = 5
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule
`endif

// File: rtl/comb_sweep_gen.sv
// comb_sweep_gen
// Exhaustive stimulus engine for a combinational block. Walks every N_IN-bit
// vector, holds each for HOLD cycles, samples dut_y on the last hold cycle,
// emits a valid/ready event whenever the sampled output changes (and for the
// first vector), and counts vectors whose sampled y[0] is 1.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : comb_sweep_gen_if master modport (start, busy, done, vec, dut_y,
//         ev_valid, ev_ready, ev_vec, ev_y, ones_cnt)
// Build option: define SWEEP_GRAY_EN to sweep in Gray order instead of
// plain binary order.
module comb_sweep_gen
    import comb_sweep_pkg::*;
#(
    parameter int N_IN  = 5,
    parameter int N_OUT = 1,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    comb_sweep_gen_if.master bus
);

    localparam int              HCW       = hold_cnt_w(HOLD);
    localparam int              CW        = ones_cnt_w(N_IN);
    localparam logic [N_IN:0]   LAST_IDX  = {1'b0, {N_IN{1'b1}}};
    localparam logic [N_IN:0]   IDX_ONE   = (N_IN+1)'(1);
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

    state_t           state;
    // One spare bit so the terminal compare cannot wrap.
    logic [N_IN:0]    idx;
    logic [HCW-1:0]   hold_cnt;
    logic             first_flag;
    logic [N_OUT-1:0] last_y;
    logic             ev_valid;
    logic [N_IN-1:0]  ev_vec;
    logic [N_OUT-1:0] ev_y;
    logic [CW-1:0]    ones_cnt;
    logic [N_IN-1:0]  vec_map;
    logic             sample_evt;

`ifdef SWEEP_GRAY_EN
    sweep_bin2gray #(.W(N_IN)) u_bin2gray (
        .bin  (idx[N_IN-1:0]),
        .gray (vec_map)
    );
`else
    assign vec_map = idx[N_IN-1:0];
`endif

    assign sample_evt = first_flag || (bus.dut_y != last_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            hold_cnt   <= '0;
            first_flag <= 1'b0;
            last_y     <= '0;
            ev_valid   <= 1'b0;
            ev_vec     <= '0;
            ev_y       <= '0;
            ones_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= DRIVE;
                        idx        <= '0;
                        hold_cnt   <= '0;
                        ones_cnt   <= '0;
                        first_flag <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        first_flag <= 1'b0;
                        if (bus.dut_y[0]) ones_cnt <= ones_cnt + CNT_ONE;
                        if (sample_evt) begin
                            last_y   <= bus.dut_y;
                            ev_vec   <= vec_map;
                            ev_y     <= bus.dut_y;
                            ev_valid <= 1'b1;
                            state    <= WAIT;
                        end else if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx      <= idx + IDX_ONE;
                            hold_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // vec stays on the sampled vector until the event is taken.
                    if (bus.ev_ready) begin
                        ev_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx      <= idx + IDX_ONE;
                            hold_cnt <= '0;
                            state    <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.vec      = vec_map;
    assign bus.busy     = (state == DRIVE) || (state == WAIT);
    assign bus.done     = (state == DONE);
    assign bus.ev_valid = ev_valid;
    assign bus.ev_vec   = ev_vec;
    assign bus.ev_y     = ev_y;
    assign bus.ones_cnt = ones_cnt;

endmodule

// File: tb/tb_comb_sweep_gen.sv
// tb_comb_sweep_gen
// Bench for comb_sweep_gen. Two instances: a 2-input AND sweep with HOLD=2
// and a 5-input sweep of y = a&b | c&~d | e with HOLD=4. Expected events,
// counts and cycle totals come from a reference model that walks the input
// space with plain arithmetic. Honours SWEEP_GRAY_EN like the design.
module tb_comb_sweep_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    comb_sweep_gen_if #(.N_IN(2), .N_OUT(1)) ifa ();
    comb_sweep_gen_if #(.N_IN(5), .N_OUT(1)) ifb ();

    // Circuits under test: a = bit0, b = bit1, c = bit2, d = bit3, e = bit4.
    assign ifa.dut_y = ifa.vec[0] & ifa.vec[1];
    assign ifb.dut_y = (ifb.vec[0] & ifb.vec[1]) | (ifb.vec[2] & ~ifb.vec[3]) | ifb.vec[4];

    comb_sweep_gen #(.N_IN(2), .N_OUT(1), .HOLD(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    comb_sweep_gen #(.N_IN(5), .N_OUT(1), .HOLD(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int tests = 0;
    int fails = 0;

    int exp_ev_vec[$];
    int exp_ev_y[$];
    int exp_ones;

    int obs_vec[$];
    int obs_ev_vec[$];
    int obs_ev_y[$];
    int busy_cnt, done_cyc, stall_cnt, unstable, done_ones;
    int first_busy, first_vec, gap_busy, restart_busy, restart_vec;

    function automatic int map_v(input int i);
`ifdef SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    function automatic int f_a(input int v);
        return (v == 3) ? 1 : 0;
    endfunction

    function automatic int f_b(input int v);
        bit a, b, c, d, e;
        a = (v & 1) != 0;  b = (v & 2) != 0;  c = (v & 4) != 0;
        d = (v & 8) != 0;  e = (v & 16) != 0;
        return ((a && b) || (c && !d) || e) ? 1 : 0;
    endfunction

    // Reference: every output change along the sweep order is one event.
    task automatic build_model(input int n_in, input bit use_b);
        int prev, y, v;
        exp_ev_vec.delete(); exp_ev_y.delete(); exp_ones = 0; prev = -1;
        for (int i = 0; i < (1 << n_in); i++) begin
            v = map_v(i);
            y = use_b ? f_b(v) : f_a(v);
            if (y != prev) begin exp_ev_vec.push_back(v); exp_ev_y.push_back(y); end
            prev = y;
            exp_ones += y;
        end
    endtask

    // Runs one sweep on the 5-input instance and records what it saw.
    // mode 0: ready always high; 1: ready low 7 cycles on 2nd event; 2: random.
    task automatic sweep_b(input int mode, input bit hold_start, input int stop_at_vec);
        int accepted, stalled, r, sv, sev, sy;
        bit in_stall;
        obs_vec.delete(); obs_ev_vec.delete(); obs_ev_y.delete();
        busy_cnt = 0; done_cyc = 0; stall_cnt = 0; unstable = 0; done_ones = -1;
        gap_busy = -1; restart_busy = -1; restart_vec = -1;
        accepted = 0; stalled = 0; in_stall = 0; sv = 0; sev = 0; sy = 0;
        @(negedge clk);
        ifb.ev_ready = 1'b1;
        ifb.start = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (!hold_start) ifb.start = 1'b0;
            if (c == 1) begin first_busy = int'(ifb.busy); first_vec = int'(ifb.vec); end
            if (done_cyc != 0) begin
                if (c == done_cyc + 1) gap_busy = int'(ifb.busy);
                if (c == done_cyc + 2) begin
                    restart_busy = int'(ifb.busy); restart_vec = int'(ifb.vec); break;
                end
                continue;
            end
            if (ifb.busy) begin
                busy_cnt++;
                if (obs_vec.size() == 0 || obs_vec[$] != int'(ifb.vec)) obs_vec.push_back(int'(ifb.vec));
            end
            if (stop_at_vec >= 0 && obs_vec.size() > stop_at_vec) break;
            if (ifb.done) begin
                done_cyc = c; done_ones = int'(ifb.ones_cnt);
                if (!hold_start) break;
                continue;
            end
            if (ifb.ev_valid) begin
                case (mode)
                    1: r = (accepted == 1 && stalled < 7) ? 0 : 1;
                    2: r = int'($urandom_range(0, 1));
                    default: r = 1;
                endcase
                if (r == 0) begin
                    stalled++; stall_cnt++;
                    if (!in_stall) begin
                        in_stall = 1'b1;
                        sv = int'(ifb.vec); sev = int'(ifb.ev_vec); sy = int'(ifb.ev_y);
                    end else if (int'(ifb.vec) != sv || int'(ifb.ev_vec) != sev || int'(ifb.ev_y) != sy) begin
                        unstable++;
                    end
                end else begin
                    if (in_stall && (int'(ifb.vec) != sv || int'(ifb.ev_vec) != sev || int'(ifb.ev_y) != sy))
                        unstable++;
                    in_stall = 1'b0;
                    obs_ev_vec.push_back(int'(ifb.ev_vec));
                    obs_ev_y.push_back(int'(ifb.ev_y));
                    accepted++;
                end
                ifb.ev_ready = (r != 0);
            end else begin
                ifb.ev_ready = (mode == 2) ? ($urandom_range(0, 1) != 0) : 1'b1;
            end
        end
        if (stop_at_vec < 0) begin
            tests++;
            if (done_cyc == 0) begin
                fails++; $display("FAIL sweep_timeout: done seen=0 required=1 (mode %0d)", mode);
            end
        end
        ifb.start = 1'b0;
        ifb.ev_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({ifa.busy, ifa.done, ifa.ev_valid, ifa.vec, ifa.ev_vec, ifa.ev_y, ifa.ones_cnt} !== '0) begin
            fails++; $display("FAIL reset_a: outputs=%h required=0",
                {ifa.busy, ifa.done, ifa.ev_valid, ifa.vec, ifa.ev_vec, ifa.ev_y, ifa.ones_cnt});
        end
        tests++;
        if ({ifb.busy, ifb.done, ifb.ev_valid, ifb.vec, ifb.ev_vec, ifb.ev_y, ifb.ones_cnt} !== '0) begin
            fails++; $display("FAIL reset_b: outputs=%h required=0",
                {ifb.busy, ifb.done, ifb.ev_valid, ifb.vec, ifb.ev_vec, ifb.ev_y, ifb.ones_cnt});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({ifb.busy, ifb.done, ifb.ev_valid} !== 3'b000) begin
            fails++; $display("FAIL idle_after_reset: busy/done/valid=%b required=000",
                {ifb.busy, ifb.done, ifb.ev_valid});
        end
    endtask

    task automatic test_small;
        int ev_v[$], ev_y[$], vt[$];
        int busy, done_n, done_c, ones;
        busy = 0; done_n = 0; done_c = 0; ones = -1;
        build_model(2, 1'b0);
        ifa.ev_ready = 1'b1;
        ifa.start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            ifa.start = 1'b0;
            if (ifa.busy) begin
                busy++;
                if (vt.size() == 0 || vt[$] != int'(ifa.vec)) vt.push_back(int'(ifa.vec));
            end
            if (ifa.ev_valid) begin ev_v.push_back(int'(ifa.ev_vec)); ev_y.push_back(int'(ifa.ev_y)); end
            if (ifa.done) begin
                done_n++;
                if (done_n == 1) begin done_c = c; ones = int'(ifa.ones_cnt); end
            end
            if (done_c != 0 && c >= done_c + 4) break;
        end
        tests++;
        if (done_n != 1) begin fails++; $display("FAIL small_done_pulses: got %0d required 1", done_n); end
        tests++;
        if (ev_v.size() != exp_ev_vec.size()) begin
            fails++; $display("FAIL small_ev_count: got %0d required %0d", ev_v.size(), exp_ev_vec.size());
        end
        for (int i = 0; i < ev_v.size() && i < exp_ev_vec.size(); i++) begin
            tests++;
            if (ev_v[i] != exp_ev_vec[i] || ev_y[i] != exp_ev_y[i]) begin
                fails++; $display("FAIL small_ev[%0d]: got vec=%0d y=%0d required vec=%0d y=%0d",
                    i, ev_v[i], ev_y[i], exp_ev_vec[i], exp_ev_y[i]);
            end
        end
        tests++;
        if (ones != exp_ones) begin fails++; $display("FAIL small_ones: got %0d required %0d", ones, exp_ones); end
        tests++;
        if (busy != 4 * 2 + exp_ev_vec.size()) begin
            fails++; $display("FAIL small_busy: got %0d required %0d", busy, 4 * 2 + exp_ev_vec.size());
        end
        tests++;
        if (done_c != busy + 1) begin fails++; $display("FAIL small_done_cycle: got %0d required %0d", done_c, busy + 1); end
        tests++;
        if (vt.size() != 4) begin fails++; $display("FAIL small_vec_count: got %0d required 4", vt.size()); end
        for (int i = 0; i < vt.size() && i < 4; i++) begin
            tests++;
            if (vt[i] != map_v(i)) begin fails++; $display("FAIL small_vec[%0d]: got %0d required %0d", i, vt[i], map_v(i)); end
        end
    endtask

    task automatic test_full_sweep;
        build_model(5, 1'b1);
        sweep_b(0, 1'b0, -1);
        tests++;
        if (first_busy != 1 || first_vec != 0) begin
            fails++; $display("FAIL full_first_cycle: got busy=%0d vec=%0d required busy=1 vec=0", first_busy, first_vec);
        end
        tests++;
        if (obs_ev_vec.size() != exp_ev_vec.size()) begin
            fails++; $display("FAIL full_ev_count: got %0d required %0d", obs_ev_vec.size(), exp_ev_vec.size());
        end
        for (int i = 0; i < obs_ev_vec.size() && i < exp_ev_vec.size(); i++) begin
            tests++;
            if (obs_ev_vec[i] != exp_ev_vec[i] || obs_ev_y[i] != exp_ev_y[i]) begin
                fails++; $display("FAIL full_ev[%0d]: got vec=%0d y=%0d required vec=%0d y=%0d",
                    i, obs_ev_vec[i], obs_ev_y[i], exp_ev_vec[i], exp_ev_y[i]);
            end
        end
        tests++;
        if (done_ones != exp_ones) begin fails++; $display("FAIL full_ones: got %0d required %0d", done_ones, exp_ones); end
        tests++;
        if (busy_cnt != 32 * 4 + exp_ev_vec.size()) begin
            fails++; $display("FAIL full_busy: got %0d required %0d", busy_cnt, 32 * 4 + exp_ev_vec.size());
        end
        tests++;
        if (done_cyc != busy_cnt + 1) begin fails++; $display("FAIL full_done_cycle: got %0d required %0d", done_cyc, busy_cnt + 1); end
        tests++;
        if (obs_vec.size() != 32) begin fails++; $display("FAIL full_vec_count: got %0d required 32", obs_vec.size()); end
        for (int i = 0; i < obs_vec.size() && i < 32; i++) begin
            tests++;
            if (obs_vec[i] != map_v(i)) begin fails++; $display("FAIL full_vec[%0d]: got %0d required %0d", i, obs_vec[i], map_v(i)); end
        end
`ifdef SWEEP_GRAY_EN
        for (int i = 1; i < obs_vec.size(); i++) begin
            tests++;
            if ($countones(obs_vec[i] ^ obs_vec[i-1]) != 1) begin
                fails++; $display("FAIL gray_step[%0d]: got %0d bit changes required 1", i, $countones(obs_vec[i] ^ obs_vec[i-1]));
            end
        end
`endif
    endtask

    task automatic test_stall;
        build_model(5, 1'b1);
        sweep_b(1, 1'b0, -1);
        tests++;
        if (stall_cnt != 7) begin fails++; $display("FAIL stall_len: got %0d required 7", stall_cnt); end
        tests++;
        if (unstable != 0) begin fails++; $display("FAIL stall_frozen: got %0d changes required 0", unstable); end
        tests++;
        if (done_cyc != 32 * 4 + exp_ev_vec.size() + 7 + 1) begin
            fails++; $display("FAIL stall_done_cycle: got %0d required %0d", done_cyc, 32 * 4 + exp_ev_vec.size() + 8);
        end
        tests++;
        if (obs_ev_vec.size() != exp_ev_vec.size()) begin
            fails++; $display("FAIL stall_ev_count: got %0d required %0d", obs_ev_vec.size(), exp_ev_vec.size());
        end
        for (int i = 0; i < obs_ev_vec.size() && i < exp_ev_vec.size(); i++) begin
            tests++;
            if (obs_ev_vec[i] != exp_ev_vec[i] || obs_ev_y[i] != exp_ev_y[i]) begin
                fails++; $display("FAIL stall_ev[%0d]: got vec=%0d y=%0d required vec=%0d y=%0d",
                    i, obs_ev_vec[i], obs_ev_y[i], exp_ev_vec[i], exp_ev_y[i]);
            end
        end
    endtask

    task automatic test_random_ready;
        build_model(5, 1'b1);
        for (int run = 0; run < 2; run++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            sweep_b(2, 1'b0, -1);
            tests++;
            if (unstable != 0) begin fails++; $display("FAIL rand_frozen: got %0d changes required 0", unstable); end
            tests++;
            if (busy_cnt != 32 * 4 + exp_ev_vec.size() + stall_cnt) begin
                fails++; $display("FAIL rand_busy: got %0d required %0d", busy_cnt, 32 * 4 + exp_ev_vec.size() + stall_cnt);
            end
            tests++;
            if (done_ones != exp_ones) begin fails++; $display("FAIL rand_ones: got %0d required %0d", done_ones, exp_ones); end
            tests++;
            if (obs_ev_vec.size() != exp_ev_vec.size()) begin
                fails++; $display("FAIL rand_ev_count: got %0d required %0d", obs_ev_vec.size(), exp_ev_vec.size());
            end
            for (int i = 0; i < obs_ev_vec.size() && i < exp_ev_vec.size(); i++) begin
                tests++;
                if (obs_ev_vec[i] != exp_ev_vec[i] || obs_ev_y[i] != exp_ev_y[i]) begin
                    fails++; $display("FAIL rand_ev[%0d]: got vec=%0d y=%0d required vec=%0d y=%0d",
                        i, obs_ev_vec[i], obs_ev_y[i], exp_ev_vec[i], exp_ev_y[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        build_model(5, 1'b1);
        sweep_b(0, 1'b0, 9);
        tests++;
        if (obs_vec.size() != 10 || obs_vec[$] != map_v(9)) begin
            fails++; $display("FAIL mid_reach_vec9: got %0d vectors required 10", obs_vec.size());
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({ifb.busy, ifb.done, ifb.ev_valid, ifb.vec, ifb.ev_vec, ifb.ev_y, ifb.ones_cnt} !== '0) begin
            fails++; $display("FAIL mid_reset_outputs: got %h required 0",
                {ifb.busy, ifb.done, ifb.ev_valid, ifb.vec, ifb.ev_vec, ifb.ev_y, ifb.ones_cnt});
        end
        rst = 1'b0;
        sweep_b(0, 1'b0, -1);
        tests++;
        if (first_busy != 1 || first_vec != 0 || obs_vec.size() != 32) begin
            fails++; $display("FAIL mid_restart: got busy=%0d vec=%0d nvec=%0d required busy=1 vec=0 nvec=32",
                first_busy, first_vec, obs_vec.size());
        end
        tests++;
        if (done_ones != exp_ones || obs_ev_vec.size() != exp_ev_vec.size()) begin
            fails++; $display("FAIL mid_resweep: got ones=%0d events=%0d required ones=%0d events=%0d",
                done_ones, obs_ev_vec.size(), exp_ones, exp_ev_vec.size());
        end
    endtask

    task automatic test_start_held;
        build_model(5, 1'b1);
        sweep_b(0, 1'b1, -1);
        tests++;
        if (busy_cnt != 32 * 4 + exp_ev_vec.size()) begin
            fails++; $display("FAIL held_busy: got %0d required %0d", busy_cnt, 32 * 4 + exp_ev_vec.size());
        end
        tests++;
        if (obs_ev_vec.size() != exp_ev_vec.size() || done_ones != exp_ones) begin
            fails++; $display("FAIL held_single_sweep: got events=%0d ones=%0d required events=%0d ones=%0d",
                obs_ev_vec.size(), done_ones, exp_ev_vec.size(), exp_ones);
        end
        tests++;
        if (gap_busy != 0) begin fails++; $display("FAIL held_idle_gap: got busy=%0d required 0", gap_busy); end
        tests++;
        if (restart_busy != 1 || restart_vec != 0) begin
            fails++; $display("FAIL held_restart: got busy=%0d vec=%0d required busy=1 vec=0", restart_busy, restart_vec);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        ifa.start = 1'b0; ifa.ev_ready = 1'b1;
        ifb.start = 1'b0; ifb.ev_ready = 1'b1;
        test_reset;
        test_small;
        test_full_sweep;
        test_stall;
        test_random_ready;
        test_reset_mid;
        test_start_held;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
